// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, the slave FSM state type and address helpers.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HALF  = 3'd1,
      WORD  = 3'd2,
      DWORD = 3'd3
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

   // True when the low address bits are not a multiple of the transfer size.
   // Sizes above DWORD are rejected separately, so 8-byte alignment is the
   // widest check needed here.
   function automatic logic size_misaligned(input logic [2:0] lo, input logic [2:0] size);
      logic [2:0] m;
      case (size)
         3'd0:    m = 3'b000;
         3'd1:    m = 3'b001;
         3'd2:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return |(lo & m);
   endfunction

endpackage

// File: rtl/ahb_lite_bytemask.sv
// Byte-lane strobe generator: 2^size consecutive lanes starting at lane.
module ahb_lite_bytemask
   import ahb_lite_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]                    size,
   input  logic [$clog2(DATA_W/8)-1:0]   lane,
   output logic [DATA_W/8-1:0]           strb
);

   localparam int unsigned BYTES = DATA_W / 8;

   // Mark every lane that falls inside [lane, lane + 2^size).
   always_comb begin
      strb = '0;
      for (int unsigned b = 0; b < BYTES; b++) begin
         if ((b >= 32'(lane)) && (b < (32'(lane) + (32'd1 << size)))) begin
            strb[b] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by a word-organised register-file memory, with
// fixed wait-state insertion, sub-word writes and a two-cycle ERROR response.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic              HMASTLOCK,
   input  logic              HREADY,
   input  logic [DATA_W-1:0] HWDATA,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP
);

   localparam int BYTES  = DATA_W / 8;
   localparam int OFFS_W = $clog2(BYTES);
   localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [2:0]        MAX_SIZE    = 3'(OFFS_W);
   localparam logic [2:0]        WAIT_LOAD   = 3'(WAIT_STATES);
   localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(DEPTH_WORDS);

   slave_state_t      state;
   slave_state_t      state_nxt;
   logic [2:0]        wait_cnt;
   logic [2:0]        wait_cnt_nxt;

   logic [IDX_W-1:0]  idx_q;
   logic [OFFS_W-1:0] lane_q;
   logic [2:0]        size_q;
   logic              write_q;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   htrans_t           trans;
   logic              accept;
   logic              accept_slot;
   logic              take;
   logic              legal;
   logic [ADDR_W-1:0] word_addr;
   logic [BYTES-1:0]  strb;

   // Burst, protection and lock attributes are carried on the bus but do
   // not change how this memory responds.
   logic              unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

   assign trans       = htrans_t'(HTRANS);
   assign accept      = HSEL && HREADY && ((trans == NONSEQ) || (trans == SEQ));
   assign word_addr   = HADDR >> OFFS_W;
   assign legal       = (word_addr < DEPTH_LIMIT) &&
                        (HSIZE <= MAX_SIZE) &&
                        !size_misaligned(3'(HADDR[OFFS_W-1:0]), HSIZE);
   // Only states that drive HREADYOUT high can overlap a new address phase.
   assign accept_slot = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
   assign take        = accept && accept_slot;

   ahb_lite_bytemask #(
      .DATA_W (DATA_W)
   ) u_bytemask (
      .size (size_q),
      .lane (lane_q),
      .strb (strb)
   );

   // State register, wait counter and address-phase capture.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         idx_q    <= '0;
         lane_q   <= '0;
         size_q   <= '0;
         write_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (take) begin
            idx_q   <= HADDR[OFFS_W +: IDX_W];
            lane_q  <= HADDR[OFFS_W-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
         end
      end
   end

   // Next-state logic and bus responses decoded from the current state.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      HREADYOUT    = 1'b1;
      HRESP        = HRESP_OKAY;
      HRDATA       = '0;

      case (state)
         ST_IDLE, ST_DATA, ST_ERR2: begin
            if (state == ST_DATA && !write_q) begin
               HRDATA = mem[idx_q];
            end
            if (state == ST_ERR2) begin
               HRESP = HRESP_ERROR;
            end
            state_nxt = ST_IDLE;
            if (take) begin
               if (!legal) begin
                  state_nxt = ST_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_nxt    = ST_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end else begin
                  state_nxt = ST_DATA;
               end
            end
         end
         ST_WAIT: begin
            HREADYOUT = 1'b0;
            if (wait_cnt == 3'd1) begin
               state_nxt = ST_DATA;
            end else begin
               wait_cnt_nxt = wait_cnt - 3'd1;
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nxt = ST_ERR2;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Commit write data under the byte strobe at the end of a write data phase.
   // Memory has no reset; a write cut off by reset never reaches ST_DATA.
   always_ff @(posedge HCLK) begin
      if (state == ST_DATA && write_q) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (strb[b]) begin
               mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule
